// File: rtl/can_port_master.sv
`default_nettype none
// ============================================================================
//  Module      : can_port_master
//  Description : Master for the multiplexed 8-bit legacy CAN register bus
//                (cs/ale/rd/wr with a shared address/data port). Converts a
//                single-byte register request on a valid/ready handshake into
//                a timed ADDR -> STROBE -> HOLD bus cycle towards one of
//                NUM_NODES controllers and returns a one-cycle response.
//                Requests addressed to a node index >= NUM_NODES produce an
//                error response without touching the bus.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        : system clock
//    rst_i        : synchronous active-high reset
//    req_valid_i  : request valid
//    req_ready_o  : request accepted when valid and ready are both high
//    req_node_i   : target node index (NW bits)
//    req_rnw_i    : 1 = read, 0 = write
//    req_addr_i   : register address
//    req_wdata_i  : write data
//    rsp_valid_o  : one-cycle completion pulse, no backpressure
//    rsp_rdata_o  : read data (0 for writes and errors)
//    rsp_err_o    : node index out of range
//    cs_o/ale_o/rd_o/wr_o : per-node chip select, latch enable, strobes
//    port_o       : driven address/data
//    port_oe_o    : output enable for the external tristate
//    port_i       : sampled port value
// ============================================================================
module can_port_master #(
    parameter int NUM_NODES     = 2,
    parameter int ALE_CYCLES    = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1,
    localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [NW-1:0]        req_node_i,
    input  logic                 req_rnw_i,
    input  logic [7:0]           req_addr_i,
    input  logic [7:0]           req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [7:0]           rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [NUM_NODES-1:0] cs_o,
    output logic [NUM_NODES-1:0] ale_o,
    output logic [NUM_NODES-1:0] rd_o,
    output logic [NUM_NODES-1:0] wr_o,
    output logic [7:0]           port_o,
    output logic                 port_oe_o,
    input  logic [7:0]           port_i
);

    // Phase counter reload values: a phase of N cycles loads N-1 and the
    // state is left when the counter reads zero (16 -> 15 fits in 4 bits).
    localparam logic [3:0] c_ALE_LOAD  = 4'(ALE_CYCLES - 1);
    localparam logic [3:0] c_STB_LOAD  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] c_HOLD_LOAD = 4'(HOLD_CYCLES - 1);
    localparam logic [NUM_NODES-1:0] c_LANE_ONE = NUM_NODES'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [NUM_NODES-1:0]   r_lane;
    logic                   r_rnw;
    logic [7:0]             r_wdata;

    logic                   r_req_ready;
    logic                   r_rsp_valid;
    logic [7:0]             r_rsp_rdata;
    logic                   r_rsp_err;
    logic [NUM_NODES-1:0]   r_cs;
    logic [NUM_NODES-1:0]   r_ale;
    logic [NUM_NODES-1:0]   r_rd;
    logic [NUM_NODES-1:0]   r_wr;
    logic [7:0]             r_port;
    logic                   r_port_oe;

    logic                   w_node_bad;
    logic [NUM_NODES-1:0]   w_lane;

    // Index check is done on the zero-extended value so that non power of
    // two node counts reject the unused upper codes.
    assign w_node_bad = (32'(req_node_i) >= NUM_NODES);
    assign w_lane     = c_LANE_ONE << req_node_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_lane      <= '0;
            r_rnw       <= 1'b0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cs        <= '0;
            r_ale       <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_port      <= '0;
            r_port_oe   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_rnw       <= req_rnw_i;
                        r_wdata     <= req_wdata_i;
                        if (w_node_bad) begin
                            // Error response is produced directly on entry
                            // to ERR so it appears in the cycle after accept.
                            r_state     <= S_ERR;
                            r_lane      <= '0;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state   <= S_ADDR;
                            r_cnt     <= c_ALE_LOAD;
                            r_lane    <= w_lane;
                            r_cs      <= w_lane;
                            r_ale     <= w_lane;
                            r_port    <= req_addr_i;
                            r_port_oe <= 1'b1;
                        end
                    end else begin
                        // Also raises ready the first cycle after reset.
                        r_req_ready <= 1'b1;
                    end
                end

                S_ADDR: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_STROBE;
                        r_cnt   <= c_STB_LOAD;
                        r_ale   <= '0;
                        if (r_rnw) begin
                            // Release the port in the same cycle rd rises.
                            r_rd      <= r_lane;
                            r_port_oe <= 1'b0;
                        end else begin
                            r_wr      <= r_lane;
                            r_port    <= r_wdata;
                            r_port_oe <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        // Read data is captured on the edge ending the last
                        // strobe cycle, while rd is still asserted.
                        r_state     <= S_HOLD;
                        r_cnt       <= c_HOLD_LOAD;
                        r_cs        <= '0;
                        r_rd        <= '0;
                        r_wr        <= '0;
                        r_port      <= '0;
                        r_port_oe   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_rnw ? port_i : 8'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_HOLD: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_ERR: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_cs        <= '0;
                    r_ale       <= '0;
                    r_rd        <= '0;
                    r_wr        <= '0;
                    r_port_oe   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = r_req_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign cs_o        = r_cs;
    assign ale_o       = r_ale;
    assign rd_o        = r_rd;
    assign wr_o        = r_wr;
    assign port_o      = r_port;
    assign port_oe_o   = r_port_oe;

endmodule
`default_nettype wire

// File: tb/tb_can_port_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_port_master
//  Description : Randomised bench for can_port_master. Two instances share one
//                random stimulus stream: instance 0 with default parameters,
//                instance 1 with NUM_NODES=3, ALE=2, STROBE=3, HOLD=2. A
//                transaction-level model derives every expected output from
//                the number of cycles elapsed since the request was accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_port_master;

    localparam int c_CYCLES = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_node;
    logic       req_rnw;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] port_in;

    logic       a_ready, a_rsp_valid, a_err, a_oe;
    logic [7:0] a_rdata, a_port;
    logic [1:0] a_cs, a_ale, a_rd, a_wr;

    logic       b_ready, b_rsp_valid, b_err, b_oe;
    logic [7:0] b_rdata, b_port;
    logic [2:0] b_cs, b_ale, b_rd, b_wr;

    always #5 clk = ~clk;

    can_port_master u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(a_ready),
        .req_node_i(req_node[0:0]), .req_rnw_i(req_rnw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata), .rsp_err_o(a_err),
        .cs_o(a_cs), .ale_o(a_ale), .rd_o(a_rd), .wr_o(a_wr),
        .port_o(a_port), .port_oe_o(a_oe), .port_i(port_in)
    );

    can_port_master #(
        .NUM_NODES(3), .ALE_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(b_ready),
        .req_node_i(req_node), .req_rnw_i(req_rnw),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata), .rsp_err_o(b_err),
        .cs_o(b_cs), .ale_o(b_ale), .rd_o(b_rd), .wr_o(b_wr),
        .port_o(b_port), .port_oe_o(b_oe), .port_i(port_in)
    );

    // Observed outputs gathered per instance, lanes zero-extended.
    logic [15:0] ob_cs [2];
    logic [15:0] ob_ale[2];
    logic [15:0] ob_rd [2];
    logic [15:0] ob_wr [2];
    logic [7:0]  ob_port[2];
    logic [7:0]  ob_rdata[2];
    logic        ob_ready[2];
    logic        ob_valid[2];
    logic        ob_err[2];
    logic        ob_oe[2];

    assign ob_cs[0]    = {14'd0, a_cs};
    assign ob_cs[1]    = {13'd0, b_cs};
    assign ob_ale[0]   = {14'd0, a_ale};
    assign ob_ale[1]   = {13'd0, b_ale};
    assign ob_rd[0]    = {14'd0, a_rd};
    assign ob_rd[1]    = {13'd0, b_rd};
    assign ob_wr[0]    = {14'd0, a_wr};
    assign ob_wr[1]    = {13'd0, b_wr};
    assign ob_port[0]  = a_port;
    assign ob_port[1]  = b_port;
    assign ob_rdata[0] = a_rdata;
    assign ob_rdata[1] = b_rdata;
    assign ob_ready[0] = a_ready;
    assign ob_ready[1] = b_ready;
    assign ob_valid[0] = a_rsp_valid;
    assign ob_valid[1] = b_rsp_valid;
    assign ob_err[0]   = a_err;
    assign ob_err[1]   = b_err;
    assign ob_oe[0]    = a_oe;
    assign ob_oe[1]    = b_oe;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    endtask

    function automatic int f_n(input int i); return (i == 0) ? 2 : 3; endfunction
    function automatic int f_a(input int i); return (i == 0) ? 1 : 2; endfunction
    function automatic int f_s(input int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int f_h(input int i); return (i == 0) ? 1 : 2; endfunction

    // Model state per instance: the cycle number within the current
    // transaction (1 = first cycle after accept) plus the latched request.
    bit         m_busy[2];
    bit         m_rst[2];
    int         m_k[2];
    int         m_node[2];
    bit         m_rnw[2];
    logic [7:0] m_addr[2];
    logic [7:0] m_wdata[2];
    logic [7:0] m_samp[2];
    int         n_rsp[2];
    int         n_errs[2];

    int          ea, es, eh, ek, elen;
    bit          ebad, chk_port;
    logic [15:0] lane, e_cs, e_ale, e_rd, e_wr;
    logic        e_oe, e_v, e_err;
    logic [7:0]  e_port, e_rdata;
    string       nm;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_node  = '0;
        req_rnw   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        port_in   = '0;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_rst[i] = 1'b1; m_k[i] = 0; m_node[i] = 0;
            m_rnw[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_samp[i] = '0;
            n_rsp[i] = 0; n_errs[i] = 0;
        end
        @(posedge clk);

        for (int cyc = 0; cyc < c_CYCLES; cyc++) begin
            @(negedge clk);
            // ---------------- compare current cycle ----------------
            for (int i = 0; i < 2; i++) begin
                nm   = (i == 0) ? "A" : "B";
                ea   = f_a(i); es = f_s(i); eh = f_h(i);
                ebad = (m_node[i] >= f_n(i));
                lane = 16'd1 << m_node[i];
                e_cs = '0; e_ale = '0; e_rd = '0; e_wr = '0;
                e_oe = 1'b0; e_v = 1'b0; e_err = 1'b0;
                e_port = '0; e_rdata = '0;
                chk_port = m_rst[i];
                if (m_busy[i]) begin
                    ek = m_k[i];
                    if (ebad) begin
                        if (ek == 1) begin e_v = 1'b1; e_err = 1'b1; end
                    end else if (ek <= ea) begin
                        e_cs = lane; e_ale = lane; e_oe = 1'b1;
                        e_port = m_addr[i]; chk_port = 1'b1;
                    end else if (ek <= ea + es) begin
                        e_cs = lane;
                        if (m_rnw[i]) e_rd = lane;
                        else begin
                            e_wr = lane; e_oe = 1'b1;
                            e_port = m_wdata[i]; chk_port = 1'b1;
                        end
                    end else if (ek == ea + es + 1) begin
                        e_v = 1'b1;
                        e_rdata = m_rnw[i] ? m_samp[i] : 8'd0;
                    end
                end
                check({nm, ".ready"}, 32'(ob_ready[i]), 32'(!m_busy[i] && !m_rst[i]));
                check({nm, ".rsp_valid"}, 32'(ob_valid[i]), 32'(e_v));
                check({nm, ".rsp_err"}, 32'(ob_err[i]), 32'(e_err));
                check({nm, ".cs"}, 32'(ob_cs[i]), 32'(e_cs));
                check({nm, ".ale"}, 32'(ob_ale[i]), 32'(e_ale));
                check({nm, ".rd"}, 32'(ob_rd[i]), 32'(e_rd));
                check({nm, ".wr"}, 32'(ob_wr[i]), 32'(e_wr));
                check({nm, ".port_oe"}, 32'(ob_oe[i]), 32'(e_oe));
                if (chk_port) check({nm, ".port"}, 32'(ob_port[i]), 32'(e_port));
                if (e_v || m_rst[i]) check({nm, ".rdata"}, 32'(ob_rdata[i]), 32'(e_rdata));
                if (ob_valid[i]) n_rsp[i]++;
                if (ob_err[i]) n_errs[i]++;
            end

            // ---------------- drive next inputs ----------------
            rst       = (cyc < 2) ? 1'b1 : ($urandom_range(0, 149) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_node  = 2'($urandom_range(0, 3));
            req_rnw   = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
            port_in   = 8'($urandom);

            // ---------------- advance model over next edge ----------------
            for (int i = 0; i < 2; i++) begin
                ea   = f_a(i); es = f_s(i); eh = f_h(i);
                ebad = (m_node[i] >= f_n(i));
                elen = ebad ? 1 : (ea + es + eh);
                if (rst) begin
                    m_rst[i]  = 1'b1;
                    m_busy[i] = 1'b0;
                end else if (m_rst[i]) begin
                    m_rst[i] = 1'b0;
                end else if (m_busy[i]) begin
                    if (!ebad && m_rnw[i] && m_k[i] == ea + es) m_samp[i] = port_in;
                    if (m_k[i] == elen) m_busy[i] = 1'b0;
                    else m_k[i] = m_k[i] + 1;
                end else if (req_valid) begin
                    m_busy[i]  = 1'b1;
                    m_k[i]     = 1;
                    m_node[i]  = (i == 0) ? int'(req_node[0]) : int'(req_node);
                    m_rnw[i]   = req_rnw;
                    m_addr[i]  = req_addr;
                    m_wdata[i] = req_wdata;
                end
            end
        end

        // The random run must actually have exercised responses and errors.
        check("A.rsp_seen", 32'(n_rsp[0] > 0), 32'd1);
        check("B.rsp_seen", 32'(n_rsp[1] > 0), 32'd1);
        check("B.err_seen", 32'(n_errs[1] > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
